// File: rtl/program_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words and writes
// them to program memory, holding the CPU until the image is complete.
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_word_count,
    input  logic [7:0]            i_byte_data,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_mem_write_enable,
    output logic [DATA_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_write_data,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

    state_t                r_state;
    logic [1:0]            r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word_idx;
    logic [DATA_WIDTH-1:0] r_count;
    // Only the first three bytes are stored; the fourth goes straight into the write word.
    logic [DATA_WIDTH-9:0] r_asm;
    logic                  r_byte_ready;
    logic                  r_mem_write_enable;
    logic [DATA_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_write_data;
    logic                  r_cpu_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] w_word_next;

    assign w_word_next = r_word_idx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state            <= S_IDLE;
            r_byte_idx         <= '0;
            r_word_idx         <= '0;
            r_count            <= '0;
            r_asm              <= '0;
            r_byte_ready       <= 1'b0;
            r_mem_write_enable <= 1'b0;
            r_mem_address      <= '0;
            r_mem_write_data   <= '0;
            r_cpu_hold         <= 1'b1;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_count    <= i_word_count;
                        r_byte_idx <= '0;
                        r_word_idx <= '0;
                        r_asm      <= '0;
                        if (i_word_count == '0) begin
                            r_state      <= S_DONE;
                            r_byte_ready <= 1'b0;
                            r_cpu_hold   <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_error      <= 1'b0;
                        end else if (i_word_count > DEPTH_W) begin
                            r_state      <= S_ERROR;
                            r_byte_ready <= 1'b0;
                            r_cpu_hold   <= 1'b1;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b0;
                            r_error      <= 1'b1;
                        end else begin
                            r_state      <= S_COLLECT;
                            r_byte_ready <= 1'b1;
                            r_cpu_hold   <= 1'b1;
                            r_busy       <= 1'b1;
                            r_done       <= 1'b0;
                            r_error      <= 1'b0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (i_byte_valid) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state            <= S_WRITE;
                            r_byte_ready       <= 1'b0;
                            r_mem_write_enable <= 1'b1;
                            r_mem_address      <= {r_word_idx[DATA_WIDTH-3:0], 2'b00};
                            r_mem_write_data   <= {i_byte_data, r_asm};
                        end else begin
                            r_asm[{r_byte_idx, 3'b000} +: 8] <= i_byte_data;
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_write_enable <= 1'b0;
                    r_word_idx         <= w_word_next;
                    if (w_word_next == r_count) begin
                        r_state    <= S_DONE;
                        r_cpu_hold <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_byte_ready       = r_byte_ready;
    assign o_mem_write_enable = r_mem_write_enable;
    assign o_mem_address      = r_mem_address;
    assign o_mem_write_data   = r_mem_write_data;
    assign o_cpu_hold         = r_cpu_hold;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_error            = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard and strobe-timing monitor.
module tb_program_loader;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_word_count;
    logic [7:0]  i_byte_data;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        o_mem_write_enable;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_write_data;
    logic        o_cpu_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_word_count(i_word_count),
        .i_byte_data(i_byte_data),
        .i_byte_valid(i_byte_valid),
        .o_byte_ready(o_byte_ready),
        .o_mem_write_enable(o_mem_write_enable),
        .o_mem_address(o_mem_address),
        .o_mem_write_data(o_mem_write_data),
        .o_cpu_hold(o_cpu_hold),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] sb[$];          // {address, data} of each expected write
    int          mon_bytes = 0;
    logic        strobe_due = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Watches the byte handshake and the write port; sampled on the falling edge.
    always @(negedge i_clk) begin
        logic [63:0] e;
        if (strobe_due || o_mem_write_enable === 1'b1) begin
            check("strobe_timing", {31'd0, o_mem_write_enable}, {31'd0, strobe_due});
            if (o_mem_write_enable === 1'b1) begin
                check("ready_low_in_write", {31'd0, o_byte_ready}, 32'd0);
                check("write_expected", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("write_addr", o_mem_address, e[63:32]);
                    check("write_data", o_mem_write_data, e[31:0]);
                end
            end
        end
        strobe_due = 1'b0;
        if (i_reset) begin
            mon_bytes = 0;
        end else if (i_byte_valid && o_byte_ready === 1'b1) begin
            if (mon_bytes == 3) strobe_due = 1'b1;
            mon_bytes = (mon_bytes + 1) % 4;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] wc);
        i_start      = 1'b1;
        i_word_count = wc;
        tick();
        i_start      = 1'b0;
        i_word_count = 32'hFFFF_FFFF;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   t;
        i_byte_valid = 1'b0;
        repeat (gap) tick();
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        t = 0;
        do begin
            @(negedge i_clk);
            acc = o_byte_ready;
            tick();
            t++;
        end while (!acc && t < 200);
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
        i_byte_valid = 1'b0;
        i_byte_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int max_gap);
        sb.push_back({addr, w});
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (o_done !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        check(tag, {31'd0, o_done}, 32'd1);
        check({tag, "_hold"}, {31'd0, o_cpu_hold}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        i_reset      = 1'b1;
        i_start      = 1'b0;
        i_word_count = 32'd0;
        i_byte_data  = 8'h00;
        i_byte_valid = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;
        @(negedge i_clk);
        check("rst_ready", {31'd0, o_byte_ready}, 32'd0);
        check("rst_we", {31'd0, o_mem_write_enable}, 32'd0);
        check("rst_addr", o_mem_address, 32'd0);
        check("rst_data", o_mem_write_data, 32'd0);
        check("rst_hold", {31'd0, o_cpu_hold}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);
        tick();

        // Basic back-to-back load
        pulse_start(32'd2);
        check("basic_busy", {31'd0, o_busy}, 32'd1);
        check("basic_ready", {31'd0, o_byte_ready}, 32'd1);
        send_word(32'h1234_5678, 32'h0, 0);
        send_word(32'hDEAD_BEEF, 32'h4, 0);
        wait_done("basic_done");

        // Same image with random gaps; also a reload from DONE
        pulse_start(32'd2);
        check("gap_done_drop", {31'd0, o_done}, 32'd0);
        check("gap_hold", {31'd0, o_cpu_hold}, 32'd1);
        send_word(32'h1234_5678, 32'h0, 3);
        send_word(32'hDEAD_BEEF, 32'h4, 3);
        wait_done("gap_done");

        // Over-range count
        pulse_start(32'd33);
        check("err_flag", {31'd0, o_error}, 32'd1);
        check("err_hold", {31'd0, o_cpu_hold}, 32'd1);
        check("err_done", {31'd0, o_done}, 32'd0);
        repeat (10) tick();
        check("err_held", {31'd0, o_error}, 32'd1);

        // Zero count from ERROR
        pulse_start(32'd0);
        check("zero_done", {31'd0, o_done}, 32'd1);
        check("zero_error", {31'd0, o_error}, 32'd0);
        check("zero_hold", {31'd0, o_cpu_hold}, 32'd0);

        // Full memory
        pulse_start(32'd32);
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            send_word(w, 32'(i * 4), (i % 3 == 0) ? 2 : 0);
        end
        wait_done("full_done");
        check("full_last_addr", o_mem_address, 32'h7C);

        // Reset in the middle of a word
        pulse_start(32'd1);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        @(negedge i_clk);
        check("midrst_ready", {31'd0, o_byte_ready}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_hold", {31'd0, o_cpu_hold}, 32'd1);
        tick();
        pulse_start(32'd1);
        send_word(32'h0403_0201, 32'h0, 0);
        wait_done("midrst_done");

        // Start while busy must be ignored
        pulse_start(32'd2);
        sb.push_back({32'h0, 32'hCAFE_F00D});
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        pulse_start(32'd5);
        check("busy_start_ignored", {31'd0, o_busy}, 32'd1);
        send_byte(8'hFE, 1);
        send_byte(8'hCA, 0);
        send_word(32'h0BAD_CAFE, 32'h4, 1);
        wait_done("busy_done");
        repeat (30) tick();
        check("busy_still_done", {31'd0, o_done}, 32'd1);

        // Reload after DONE
        pulse_start(32'd1);
        check("reload_done_drop", {31'd0, o_done}, 32'd0);
        check("reload_hold", {31'd0, o_cpu_hold}, 32'd1);
        send_word(32'hDDCC_BBAA, 32'h0, 0);
        wait_done("reload_done");
        check("reload_addr", o_mem_address, 32'h0);
        check("reload_data", o_mem_write_data, 32'hDDCC_BBAA);

        repeat (5) tick();
        check("final_sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of the instruction ROM. Receives a byte stream (e.g. from a UART receiver) through a valid/ready handshake.
- Assembles the bytes into little-endian DATA_WIDTH-bit instruction words and issues one-cycle write strobes into a writable program memory at consecutive word-aligned byte addresses.
- Holds the processor (cpu_hold) until a complete image has been loaded.

Parameters:
- MEMORY_DEPTH, 32, number of instruction words in program memory; maximum loadable image size.
- DATA_WIDTH, 32, instruction word and address width; fixed at 32 (4 bytes per word).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load when state is IDLE, DONE or ERROR
- word_count  input  DATA_WIDTH  number of words to load; sampled only in the cycle start is accepted
- byte_data  input  8  incoming byte
- byte_valid  input  1  byte_data is valid this cycle
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready
- mem_write_enable  output  1  one-cycle write strobe to program memory
- mem_address  output  DATA_WIDTH  byte address of the write, always word-aligned (bits [1:0] = 0)
- mem_write_data  output  DATA_WIDTH  assembled instruction word
- cpu_hold  output  1  keeps the processor stalled/reset while high
- busy  output  1  high in COLLECT and WRITE
- done  output  1  image fully written
- error  output  1  word_count out of range

Behaviour:
- FSM states: IDLE, COLLECT, WRITE, DONE, ERROR. All outputs are Moore outputs of the state plus internal registers. No combinational path from inputs to outputs.
- Reset values:
  - state = IDLE.
  - byte_ready = 0, mem_write_enable = 0, mem_address = 0, mem_write_data = 0.
  - cpu_hold = 1, busy = 0, done = 0, error = 0.
  - Internal byte_idx = 0, word_idx = 0, count = 0.
- IDLE, DONE or ERROR with start = 1:
  - Latch count = word_count; clear byte_idx, word_idx and the assembly register.
  - Next state: if word_count == 0 then DONE; else if word_count > MEMORY_DEPTH then ERROR; else COLLECT.
- COLLECT:
  - byte_ready = 1.
  - On each transfer, the byte is written into assembly bits [8*byte_idx+7 : 8*byte_idx] (first byte is the LSB), and byte_idx increments mod 4.
  - The transfer with byte_idx == 3 moves to WRITE on the next edge.
  - Cycles with byte_valid = 0 change nothing.
- WRITE (exactly one cycle):
  - byte_ready = 0, mem_write_enable = 1.
  - mem_address = word_idx << 2; mem_write_data = assembled word.
  - On exit, word_idx increments. If the new word_idx == count, next state is DONE; else COLLECT.
- Latency: the 4th byte is accepted at edge N; mem_write_enable is high during the cycle following edge N. The maximum rate is one word per 5 cycles.
- DONE: done = 1, cpu_hold = 0, byte_ready = 0. Held until a new start or reset.
- ERROR: error = 1, cpu_hold = 1, no writes. Held until start or reset.
- cpu_hold = 1 in IDLE, COLLECT, WRITE and ERROR; 0 only in DONE.
- Outside WRITE: mem_write_enable = 0, and mem_address / mem_write_data hold their last values.
- start during COLLECT or WRITE is ignored. word_count changes after start are ignored.
- Bytes presented while byte_ready = 0 are not consumed. The source must hold them.
- reset mid-load (any state) returns to IDLE next edge:
  - A partially assembled word is discarded.
  - No write strobe is produced in the reset cycle or after.
- word_idx never exceeds MEMORY_DEPTH-1 when a write is issued. Highest address = (MEMORY_DEPTH-1)*4.

Test Plan:
- Basic load:
  - Stimulus: reset, start with word_count = 2, stream bytes 78 56 34 12 EF BE AD DE back-to-back.
  - Response: write 0x12345678 @ 0x0, then 0xDEADBEEF @ 0x4. Each strobe is one cycle, one cycle after the 4th byte. Then done = 1 and cpu_hold = 0.
- Backpressure and gaps:
  - Stimulus: same image with byte_valid idle 0-3 random cycles between bytes.
  - Response: identical writes. No byte lost or duplicated. byte_ready = 0 during WRITE.
- Boundaries:
  - word_count = 0: done next cycle, no strobes.
  - word_count = 32: last write @ 0x7C.
  - word_count = 33: error = 1, cpu_hold = 1, no strobes.
- Reset mid-word:
  - Stimulus: start with word_count = 1, send 2 bytes, assert reset, then start again with word_count = 1 and bytes 01 02 03 04.
  - Response: a single write 0x04030201 @ 0x0. The stale bytes are discarded.
- Start while busy:
  - Stimulus: pulse start with word_count = 5 during a 2-word load.
  - Response: ignored; exactly 2 writes, then done.
- Reload:
  - Stimulus: after DONE, start with word_count = 1 and bytes AA BB CC DD.
  - Response: done drops, cpu_hold = 1; write 0xDDCCBBAA @ 0x0; done reasserts.
